// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory with fixed-latency dual-read responses.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_we/req_addr0/req_addr1/req_wdata
//   request side; rsp_valid/rsp_ready/rsp_data0/rsp_data1 response side.
// Optional macro DMEM_STATS_EN adds stat_reads/stat_writes (16-bit saturating counters).
module dmem_responder #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [$clog2(DEPTH)-1:0] req_addr0,
    input  logic [$clog2(DEPTH)-1:0] req_addr1,
    input  logic [WIDTH-1:0]         req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data0,
    output logic [WIDTH-1:0]         rsp_data1
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]              stat_reads,
    output logic [15:0]              stat_writes
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr0_q, addr0_d;
    logic [AW-1:0]    addr1_q, addr1_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rsp_data0_q, rsp_data0_d;
    logic [WIDTH-1:0] rsp_data1_q, rsp_data1_d;
    logic [WIDTH-1:0] data [DEPTH];
    logic             accept;
    logic             commit;

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data0 = rsp_data0_q;
    assign rsp_data1 = rsp_data1_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr0_d     = addr0_q;
        addr1_d     = addr1_q;
        wdata_d     = wdata_q;
        rsp_data0_d = rsp_data0_q;
        rsp_data1_d = rsp_data1_q;
        commit      = 1'b0;
        accept      = req_valid && req_ready;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr0_d = req_addr0;
                    addr1_d = req_addr1;
                    wdata_d = req_wdata;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit      = we_q;
                    // Write-first: the committing word is returned on any port that names it.
                    rsp_data0_d = we_q ? wdata_q : data[addr0_q];
                    rsp_data1_d = (we_q && addr1_q == addr0_q) ? wdata_q : data[addr1_q];
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr0_q     <= '0;
            addr1_q     <= '0;
            wdata_q     <= '0;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr0_q     <= addr0_d;
            addr1_q     <= addr1_d;
            wdata_q     <= wdata_d;
            rsp_data0_q <= rsp_data0_d;
            rsp_data1_q <= rsp_data1_d;
            if (commit) begin
                data[addr0_q] <= wdata_q;
            end
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] stat_reads_q, stat_reads_d;
    logic [15:0] stat_writes_q, stat_writes_d;

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;

    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        if (accept && !req_we && stat_reads_q != 16'hFFFF) begin
            stat_reads_d = stat_reads_q + 16'd1;
        end
        if (accept && req_we && stat_writes_q != 16'hFFFF) begin
            stat_writes_d = stat_writes_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
        end
    end
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of words; power of two, >= 2.
REQ-003 Parameter LATENCY, default 2, cycles from request accept to response; >= 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  CPU presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = write data[req_addr0], 0 = read only.
REQ-009 req_addr0  input  $clog2(DEPTH)  first read address, also write address.
REQ-010 req_addr1  input  $clog2(DEPTH)  second read address.
REQ-011 req_wdata  input  WIDTH  write data.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  CPU consumes the response.
REQ-014 rsp_data0  output  WIDTH  word at addr0.
REQ-015 rsp_data1  output  WIDTH  word at addr1.
REQ-016 Storage SHALL be an internal array named data[0..DEPTH-1] of WIDTH bits, reachable hierarchically by benches.

Function
REQ-017 FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE and not in reset.
REQ-018 IDLE: on req_valid&&req_ready, latch we/addr0/addr1/wdata, load counter with LATENCY-1, go WAIT; otherwise stay IDLE.
REQ-019 WAIT: counter decrements each cycle; at counter==0 go RESP, so rsp_valid rises exactly LATENCY edges after the accept edge.
REQ-020 Write commit: on the WAIT->RESP edge, data[addr0] <= wdata when we=1; no array change before that edge.
REQ-021 On the WAIT->RESP edge rsp_data0/1 SHALL load data[addr0]/data[addr1] as they are after the commit (write-first; addr1==addr0 returns new value on both).
REQ-022 RESP: rsp_valid=1, rsp_data0/1 stable until rsp_valid&&rsp_ready; then go IDLE, rsp_valid 0 next cycle, rsp_data0/1 hold last value.
REQ-023 req_valid in WAIT or RESP SHALL be ignored (no queueing); at most one outstanding request.
REQ-024 rsp_ready while not in RESP SHALL have no effect.
REQ-025 Minimum request-to-request spacing SHALL be LATENCY+2 cycles with rsp_ready held 1.

Reset
REQ-026 While rst=1 at a rising edge: state IDLE, counter 0, rsp_valid 0, rsp_data0/1 0, every data[i] 0, req_ready 0.
REQ-027 Reset during WAIT SHALL discard the pending request, including an uncommitted write.
REQ-028 Reset during RESP SHALL drop the response; no rsp_valid after rst deasserts until a new request.
REQ-029 First cycle after rst deasserts: req_ready=1.

Configuration
REQ-030 Macro DMEM_STATS_EN defined: outputs stat_reads and stat_writes (16 bits each) exist; +1 per accepted read/write respectively, saturating at 16'hFFFF, cleared by rst.
REQ-031 DMEM_STATS_EN undefined: stat ports and counters absent; all other behaviour identical.

Verification
REQ-032 Reset: hold rst 2 cycles -> data[0..7]=0, rsp_valid=0, req_ready=0 during rst and 1 the cycle after.
REQ-033 Write then read: write addr0=3 wdata=8'hA5, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_data0=8'hA5; then read addr0=3 addr1=0 -> rsp_data0=8'hA5, rsp_data1=8'h00.
REQ-034 Same-address write: we=1 addr0=5 addr1=5 wdata=8'h3C -> rsp_data0=rsp_data1=8'h3C.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0, req_valid pulses ignored; rsp_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-write: write addr0=7 wdata=8'hFF, assert rst one cycle after accept -> data[7]=8'h00, no rsp_valid after release.
REQ-037 With DMEM_STATS_EN: 3 reads and 2 writes -> stat_reads=3, stat_writes=2; rst -> both 0.
